regfile_scanner: RTL
====================

Name: regfile_scanner

Overview:
- Read-side initiator for the CPU register file. Drives a register-file read port (address out, data back after a fixed latency) and walks one register or a range of registers.
- Presents each value as an index/data pair on a valid/ready output stream for the display/debug path driven by the board switches.
- Sits beside the datapath on a spare read port and never writes the register file.

Parameters:
- NUM_REGS, 32, number of architectural registers. Power of two, at most 2^ADDR_W.
- ADDR_W, 5, register index width.
- DATA_W, 32, register data width.
- READ_LATENCY, 1, clock cycles from rf_raddr change to valid rf_rdata. Range 1..4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request pulse. Sampled only in IDLE.
- single  in  1  sampled with start. 1 = read start_idx only; 0 = sweep start_idx..NUM_REGS-1.
- start_idx  in  ADDR_W  first register index. Sampled with start.
- abort  in  1  terminates an active scan.
- rf_raddr  out  ADDR_W  register-file read address.
- rf_rdata  in  DATA_W  register-file read data, valid READ_LATENCY cycles after rf_raddr.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_index  out  ADDR_W  index of the presented value.
- out_data  out  DATA_W  presented register value.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a scan completes or aborts.

Behaviour:
- Reset (asynchronous, active-high) forces the following while asserted:
  - state to IDLE;
  - rf_raddr, out_index, out_data, the latency counter and the captured mode to 0;
  - out_valid, busy and done to 0.
- Reset mid-scan discards everything; no partial output is produced.
- FSM states: IDLE, ISSUE, WAIT, PRESENT, DONE.
- IDLE:
  - start=1 captures single, loads the current index cur=start_idx, drives rf_raddr=start_idx, then goes to ISSUE.
  - start in any other state is ignored.
- ISSUE: load the latency counter with READ_LATENCY-1, go to WAIT. rf_raddr is held at cur.
- WAIT:
  - Count down. When the counter reaches 0, capture out_data<=rf_rdata and out_index<=cur, set out_valid, go to PRESENT.
  - Total from entering ISSUE to out_valid high is READ_LATENCY+1 cycles.
- PRESENT:
  - out_valid, out_index and out_data are held stable until out_valid&out_ready. The transfer happens on that cycle.
  - On transfer, out_valid is cleared on the same edge.
  - Go to DONE if single=1 or cur=NUM_REGS-1. Otherwise cur<=cur+1, rf_raddr<=cur+1, go to ISSUE.
  - cur never wraps. A sweep ending at NUM_REGS-1 terminates rather than returning to 0.
- DONE: done=1 for exactly one cycle, busy deasserts on the next cycle, go to IDLE.
- Register x0: the value is passed through exactly as returned by the register file; this block does no special casing.
- start_idx >= NUM_REGS (only when NUM_REGS < 2^ADDR_W): the request is accepted, one read of that index is presented, then DONE. This matches the single-element case.
- abort:
  - Takes effect in ISSUE, WAIT or PRESENT: out_valid goes low the next cycle and the state goes to DONE.
  - A pending unaccepted beat is dropped.
  - If abort and a transfer happen in the same cycle, the transfer counts and the state goes to DONE.
  - abort in IDLE or DONE has no effect.
- Throughput: one beat per READ_LATENCY+2 cycles when out_ready is held high.
- Data coherence: the value is the register contents at the sample edge. Writes to the register file during a sweep are visible for indices not yet read.

Decomposition:
- Shared package (cpu_pkg) holds:
  - the FSM state encoding (3-bit enum of IDLE/ISSUE/WAIT/PRESENT/DONE);
  - REG_ADDR_W=5, REG_DATA_W=32 and NUM_REGS=32 as localparam constants, also used by the register file.
- No sub-module is required. The latency counter stays inline; it is at most 2 bits.

Test Plan:
- Reset, single read, default latency: register file holds reg[i]=i. start=1, single=1, start_idx=7, out_ready=1.
  - Expect rf_raddr=7, out_valid high 2 cycles after ISSUE, out_index=7, out_data=7.
  - Expect a done pulse 1 cycle after the transfer, and busy low afterwards.
- Full sweep: start_idx=0, single=0, out_ready=1 → 32 beats, indices 0..31 in order, data=index, one beat every 3 cycles; done after index 31 with no wrap to 0.
- Backpressure: sweep from 28, out_ready low for 5 cycles on beat 29.
  - out_valid, out_index=29 and out_data stay stable throughout.
  - Indices 28..31 are each delivered exactly once.
- Abort: sweep from 0, assert abort while in WAIT for index 4 → indices 0..3 delivered, out_valid low next cycle, single done pulse, no beat for 4. Separately, abort coinciding with a transfer → that beat counts, then done.
- READ_LATENCY=3 build: single read of index 5 with the register file delaying data 3 cycles.
  - out_valid rises 4 cycles after ISSUE with out_data=5.
  - A data value changed on the register-file side after sampling does not alter out_data.
- Asynchronous reset mid-PRESENT, with out_valid=1 and out_ready=0: assert reset between clock edges.
  - All outputs go to 0 immediately, with no done pulse.
  - After release, a new start runs normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the register-file scanner state encoding.
// The register file uses the same address and data widths.
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_PRESENT = 3'd3,
        ST_DONE    = 3'd4
    } scan_state_t;

endpackage

// File: rtl/regfile_scanner.sv
// Read-only register-file scanner: reads one register or sweeps a range and
// streams each index/data pair out on a valid/ready interface.
module regfile_scanner #(
    parameter int NUM_REGS     = cpu_pkg::NUM_REGS,
    parameter int ADDR_W       = cpu_pkg::REG_ADDR_W,
    parameter int DATA_W       = cpu_pkg::REG_DATA_W,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              single,
    input  logic [ADDR_W-1:0] start_idx,
    input  logic              abort,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_index,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);
    import cpu_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic [1:0]        LAT_LOAD = 2'(READ_LATENCY - 1);

    scan_state_t       state, state_nxt;
    logic [ADDR_W-1:0] cur;
    logic              single_q;
    logic [1:0]        lat_cnt;
    logic              xfer;
    logic              last_beat;

    assign xfer = out_valid & out_ready;
    // Out-of-range start indices also land here, so they behave as a single read.
    assign last_beat = single_q || (cur >= LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:    if (start) state_nxt = ST_ISSUE;
            ST_ISSUE:   state_nxt = abort ? ST_DONE : ST_WAIT;
            ST_WAIT: begin
                if (abort)               state_nxt = ST_DONE;
                else if (lat_cnt == 2'd0) state_nxt = ST_PRESENT;
            end
            // A transfer coinciding with abort still counts; both end in DONE.
            ST_PRESENT: begin
                if (abort || (xfer && last_beat)) state_nxt = ST_DONE;
                else if (xfer)                    state_nxt = ST_ISSUE;
            end
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur       <= '0;
            single_q  <= 1'b0;
            lat_cnt   <= 2'd0;
            rf_raddr  <= '0;
            out_valid <= 1'b0;
            out_index <= '0;
            out_data  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        single_q <= single;
                        cur      <= start_idx;
                        rf_raddr <= start_idx;
                    end
                end
                ST_ISSUE: lat_cnt <= LAT_LOAD;
                ST_WAIT: begin
                    if (!abort) begin
                        if (lat_cnt == 2'd0) begin
                            out_data  <= rf_rdata;
                            out_index <= cur;
                            out_valid <= 1'b1;
                        end else begin
                            lat_cnt <= lat_cnt - 2'd1;
                        end
                    end
                end
                ST_PRESENT: begin
                    if (xfer || abort) out_valid <= 1'b0;
                    if (xfer && !abort && !last_beat) begin
                        cur      <= cur + 1'b1;
                        rf_raddr <= cur + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
